toccata_pb_ctrl: RTL and testbench

Playback controller for the Toccata sound path. It owns the 1 KiB playback FIFO and latches the mode configuration written by the host. It sequences start, prefill, run and flush, then drives the enable and mode inputs of the playback datapath. It also raises half-empty and underrun interrupts toward the Zorro register block.

---
 rtl/toccata_pkg.sv | 37 +++
 rtl/toccata_fifo.sv | 88 ++++++++
 rtl/toccata_pb_ctrl.sv | 171 +++++++++++++++++
 tb/tb_toccata_pb_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toccata_pkg.sv
// Shared definitions for the Toccata playback controller: FSM state codes,
// config-word and status-word bit positions, and the datapath mode bundle.
package toccata_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_STOP    = 2'd0;
  localparam state_t ST_PREFILL = 2'd1;
  localparam state_t ST_RUN     = 2'd2;
  localparam state_t ST_FLUSH   = 2'd3;

  localparam int CFG_W       = 10;
  localparam int CFG_PEN     = 0;
  localparam int CFG_FREQ_LO = 1;
  localparam int CFG_FREQ_W  = 3;
  localparam int CFG_SM      = 4;
  localparam int CFG_LC      = 5;
  localparam int CFG_FMT     = 6;
  localparam int CFG_CSS     = 7;
  localparam int CFG_HIE     = 8;
  localparam int CFG_UIE     = 9;

  localparam int STAT_W   = 4;
  localparam int STAT_RUN = 0;
  localparam int STAT_HEF = 1;
  localparam int STAT_URF = 2;
  localparam int STAT_PRE = 3;

  typedef struct packed {
    logic [CFG_FREQ_W-1:0] freq_sel;
    logic                  sm;
    logic                  lc;
    logic                  fmt;
    logic                  css;
  } pb_mode_t;

endpackage

// File: rtl/toccata_fifo.sv
// Byte-wide synchronous FIFO with registered read data, level, full and empty,
// plus a synchronous clear that empties it and drops any same-cycle access.
module toccata_fifo #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     wr_fire,
  output logic                     rd_fire
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [7:0]    rd_data_q, rd_data_d;

  assign wr_fire = wr_en & ~full_q & ~clr;
  assign rd_fire = rd_en & ~empty_q & ~clr;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers are AW bits wide, so the +1 wraps modulo DEPTH on its own.
      if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_fire) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        rd_data_d = mem[rd_ptr_q];
      end
      level_d = level_q + LW'(wr_fire) - LW'(rd_fire);
    end
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  // NOTE: the storage array has no reset; clearing 1 KiB would defeat RAM inference
  // and nothing reads a location before it has been written.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign level   = level_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/toccata_pb_ctrl.sv
// Toccata playback controller: sequences STOP/PREFILL/RUN/FLUSH around the
// playback FIFO, drives the datapath mode/enable and raises sticky interrupts.
module toccata_pb_ctrl
  import toccata_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int PREFILL_LVL = 512,
  parameter int FLUSH_WAIT  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CFG_W-1:0]       cfg_wdata,
  input  logic                   fifo_we,
  input  logic [7:0]             fifo_wdata,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_level,
  input  logic [1:0]             stat_clr,
  output logic [STAT_W-1:0]      status,
  output logic                   irq,
  output logic                   pb_pen,
  output logic                   pb_sm,
  output logic                   pb_lc,
  output logic                   pb_fmt,
  output logic                   pb_css,
  output logic [CFG_FREQ_W-1:0]  pb_freq_sel,
  input  logic                   pb_rd_en,
  output logic [7:0]             pb_data,
  output logic                   pb_empty,
  input  logic                   pb_rst_fifo
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(FLUSH_WAIT) + 1;

  state_t        state_q, state_d;
  pb_mode_t      mode_q, mode_d, cfg_mode;
  logic          pen_q, pen_d;
  logic          hie_q, hie_d, uie_q, uie_d;
  logic          hef_q, hef_d, urf_q, urf_d;
  logic          irq_q, irq_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;

  logic pen_req, flush_done, rst_fifo_ok, fifo_clr, host_we;
  logic wr_fire, rd_fire, hef_set, urf_set;

  assign pen_req     = cfg_wdata[CFG_PEN];
  assign flush_done  = (state_q == ST_FLUSH) && (flush_cnt_q == CW'(FLUSH_WAIT - 1));
  // The datapath's FIFO reset is ignored while FLUSH owns the FIFO.
  assign rst_fifo_ok = pb_rst_fifo && (state_q != ST_FLUSH);
  assign fifo_clr    = flush_done | rst_fifo_ok;
  assign host_we     = fifo_we && (state_q != ST_FLUSH);

  assign cfg_mode = '{
    freq_sel: cfg_wdata[CFG_FREQ_LO +: CFG_FREQ_W],
    sm:       cfg_wdata[CFG_SM],
    lc:       cfg_wdata[CFG_LC],
    fmt:      cfg_wdata[CFG_FMT],
    css:      cfg_wdata[CFG_CSS]
  };

  toccata_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (fifo_clr),
    .wr_en   (host_we),
    .wr_data (fifo_wdata),
    .rd_en   (pb_rd_en),
    .rd_data (pb_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (pb_empty),
    .wr_fire (wr_fire),
    .rd_fire (rd_fire)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hie_d   = hie_q;
    uie_d   = uie_q;
    if (cfg_we) begin
      hie_d = cfg_wdata[CFG_HIE];
      uie_d = cfg_wdata[CFG_UIE];
    end

    case (state_q)
      ST_STOP: begin
        if (cfg_we) begin
          mode_d = cfg_mode;
          if (pen_req) state_d = ST_PREFILL;
        end
      end
      ST_PREFILL: begin
        if (cfg_we && !pen_req) begin
          state_d = ST_FLUSH;
        end else if (!rst_fifo_ok &&
                     (fifo_level >= LW'(PREFILL_LVL) || fifo_full)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cfg_we && !pen_req) begin
          state_d = ST_FLUSH;
        end else begin
          // Only rate and channel select may change while audio is flowing.
          if (cfg_we) begin
            mode_d.freq_sel = cfg_mode.freq_sel;
            mode_d.css      = cfg_mode.css;
          end
          if (rst_fifo_ok) state_d = ST_PREFILL;
        end
      end
      ST_FLUSH: begin
        if (flush_done) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase

    flush_cnt_d = (state_q == ST_FLUSH) ? flush_cnt_q + CW'(1) : '0;
    pen_d       = (state_d == ST_RUN);

    // Flags fire only on a net drain crossing the threshold while playing.
    hef_set = (state_q == ST_RUN) && rd_fire && !wr_fire && (fifo_level == LW'(DEPTH / 2));
    urf_set = (state_q == ST_RUN) && rd_fire && !wr_fire && (fifo_level == LW'(1));
    hef_d   = hef_set | (hef_q & ~stat_clr[0]);
    urf_d   = urf_set | (urf_q & ~stat_clr[1]);
    irq_d   = (hef_q & hie_q) | (urf_q & uie_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STOP;
      mode_q      <= '0;
      pen_q       <= 1'b0;
      hie_q       <= 1'b0;
      uie_q       <= 1'b0;
      hef_q       <= 1'b0;
      urf_q       <= 1'b0;
      irq_q       <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pen_q       <= pen_d;
      hie_q       <= hie_d;
      uie_q       <= uie_d;
      hef_q       <= hef_d;
      urf_q       <= urf_d;
      irq_q       <= irq_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    status           = '0;
    status[STAT_RUN] = (state_q == ST_RUN);
    status[STAT_HEF] = hef_q;
    status[STAT_URF] = urf_q;
    status[STAT_PRE] = (state_q == ST_PREFILL);
  end

  assign irq         = irq_q;
  assign pb_pen      = pen_q;
  assign pb_sm       = mode_q.sm;
  assign pb_lc       = mode_q.lc;
  assign pb_fmt      = mode_q.fmt;
  assign pb_css      = mode_q.css;
  assign pb_freq_sel = mode_q.freq_sel;

endmodule

// File: tb/tb_toccata_pb_ctrl.sv
// Directed bench for toccata_pb_ctrl: stimulus pushes expected bytes into a
// scoreboard queue that a negedge monitor drains whenever a read completes.
module tb_toccata_pb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [9:0]  cfg_wdata;
  logic        fifo_we;
  logic [7:0]  fifo_wdata;
  logic        fifo_full;
  logic [10:0] fifo_level;
  logic [1:0]  stat_clr;
  logic [3:0]  status;
  logic        irq;
  logic        pb_pen, pb_sm, pb_lc, pb_fmt, pb_css;
  logic [2:0]  pb_freq_sel;
  logic        pb_rd_en;
  logic [7:0]  pb_data;
  logic        pb_empty;
  logic        pb_rst_fifo;

  int          errors = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  last_rd = 8'h00;

  toccata_pb_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_wdata   (cfg_wdata),
    .fifo_we     (fifo_we),
    .fifo_wdata  (fifo_wdata),
    .fifo_full   (fifo_full),
    .fifo_level  (fifo_level),
    .stat_clr    (stat_clr),
    .status      (status),
    .irq         (irq),
    .pb_pen      (pb_pen),
    .pb_sm       (pb_sm),
    .pb_lc       (pb_lc),
    .pb_fmt      (pb_fmt),
    .pb_css      (pb_css),
    .pb_freq_sel (pb_freq_sel),
    .pb_rd_en    (pb_rd_en),
    .pb_data     (pb_data),
    .pb_empty    (pb_empty),
    .pb_rst_fifo (pb_rst_fifo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] pat(input int n);
    return 8'((n * 37 + 11) & 255);
  endfunction

  task automatic host_wr(input bit accept);
    fifo_wdata = pat(wr_cnt);
    wr_cnt++;
    fifo_we = 1'b1;
    if (accept) exp_q.push_back(fifo_wdata);
    cyc(1);
    fifo_we = 1'b0;
  endtask

  task automatic cfg(input logic [9:0] v);
    cfg_we    = 1'b1;
    cfg_wdata = v;
    cyc(1);
    cfg_we    = 1'b0;
  endtask

  task automatic rd(input int n);
    pb_rd_en = 1'b1;
    cyc(n);
    pb_rd_en = 1'b0;
  endtask

  // Scoreboard monitor: a read seen before one negedge is checked at the next.
  initial begin
    logic pend;
    logic [7:0] e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pb_data: got %0d with no byte expected (t=%0t)", pb_data, $time);
        end else begin
          e = exp_q.pop_front();
          last_rd = e;
          check("pb_data", pb_data, e);
        end
      end
      pend = rst_n && pb_rd_en && !pb_empty && !pb_rst_fifo;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    cfg_we      = 1'b0;
    cfg_wdata   = '0;
    fifo_we     = 1'b0;
    fifo_wdata  = '0;
    stat_clr    = '0;
    pb_rd_en    = 1'b0;
    pb_rst_fifo = 1'b0;
    cyc(2);
    check("rst pb_pen", pb_pen, 0);
    check("rst pb_empty", pb_empty, 1);
    check("rst pb_data", pb_data, 0);
    check("rst level", fifo_level, 0);
    check("rst full", fifo_full, 0);
    check("rst status", status, 0);
    check("rst irq", irq, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // 0x3D1: pen_req, sm, fmt, css, hie, uie set; lc=0, freq_sel=0.
    cfg(10'h3D1);
    check("prefill status", status, 4'b1000);
    check("latch sm", pb_sm, 1);
    check("latch lc", pb_lc, 0);
    check("latch fmt", pb_fmt, 1);
    check("latch css", pb_css, 1);
    check("latch freq", pb_freq_sel, 0);
    check("prefill pen", pb_pen, 0);

    for (int i = 0; i < 511; i++) host_wr(1'b1);
    cyc(2);
    check("511 level", fifo_level, 511);
    check("511 pen held", pb_pen, 0);
    check("511 status", status, 4'b1000);
    host_wr(1'b1);
    check("512 pen +1", pb_pen, 0);
    cyc(1);
    check("512 pen +2", pb_pen, 1);
    check("run status", status, 4'b0001);

    // Half-empty: 512 -> 511 in RUN.
    rd(1);
    check("hef level", fifo_level, 511);
    check("hef status", status, 4'b0011);
    check("hef irq lag", irq, 0);
    cyc(1);
    check("hef irq", irq, 1);
    stat_clr = 2'b01;
    cyc(1);
    stat_clr = 2'b00;
    check("hef clr status", status, 4'b0001);
    check("hef clr irq lag", irq, 1);
    cyc(1);
    check("hef clr irq", irq, 0);

    // Drain to 1, then a read+write pair must not underrun.
    rd(510);
    check("drain level", fifo_level, 1);
    pb_rd_en = 1'b1;
    host_wr(1'b1);
    pb_rd_en = 1'b0;
    check("rw level", fifo_level, 1);
    check("rw no urf", status, 4'b0001);
    rd(1);
    check("urf level", fifo_level, 0);
    check("urf empty", pb_empty, 1);
    check("urf status", status, 4'b0101);
    check("urf irq lag", irq, 0);
    cyc(1);
    check("urf irq", irq, 1);
    rd(1);
    cyc(1);
    check("empty rd hold", pb_data, last_rd);
    check("empty rd level", fifo_level, 0);
    stat_clr = 2'b10;
    cyc(1);
    stat_clr = 2'b00;
    check("urf clr status", status, 4'b0001);
    cyc(1);
    check("urf clr irq", irq, 0);

    // Live update in RUN: freq_sel=5, css=0 taken; sm/fmt=0 ignored.
    cfg(10'h30B);
    check("live freq", pb_freq_sel, 5);
    check("live css", pb_css, 0);
    check("live fmt kept", pb_fmt, 1);
    check("live sm kept", pb_sm, 1);
    check("live pen", pb_pen, 1);
    for (int i = 0; i < 3; i++) host_wr(1'b1);
    check("pre-flush level", fifo_level, 3);
    cfg(10'h300);
    check("flush pen", pb_pen, 0);
    check("flush status", status, 4'b0000);
    host_wr(1'b0);
    cyc(14);
    check("flush wait level", fifo_level, 3);
    cyc(1);
    check("flush done level", fifo_level, 0);
    check("flush done empty", pb_empty, 1);
    check("stop status", status, 4'b0000);
    exp_q.delete();

    // STOP accepts a new mode; fill to full and beyond.
    cfg(10'h011);
    check("stop sm", pb_sm, 1);
    check("stop fmt", pb_fmt, 0);
    check("stop css", pb_css, 0);
    check("stop freq", pb_freq_sel, 0);
    check("prefill2 status", status, 4'b1000);
    for (int i = 0; i < 1024; i++) host_wr(1'b1);
    check("full level", fifo_level, 1024);
    check("full flag", fifo_full, 1);
    check("full run", status, 4'b0001);
    host_wr(1'b0);
    check("drop level", fifo_level, 1024);
    rd(4);
    check("after rd4 level", fifo_level, 1020);
    check("after rd4 full", fifo_full, 0);
    for (int i = 0; i < 4; i++) host_wr(1'b1);
    check("wrap full", fifo_full, 1);
    pb_rst_fifo = 1'b1;
    host_wr(1'b0);
    pb_rst_fifo = 1'b0;
    exp_q.delete();
    check("rstfifo level", fifo_level, 0);
    check("rstfifo empty", pb_empty, 1);
    check("rstfifo full", fifo_full, 0);
    check("rstfifo status", status, 4'b1000);
    check("rstfifo pen", pb_pen, 0);

    // Back to RUN, drain to 300 (hie=0 masks hef), then async reset.
    for (int i = 0; i < 512; i++) host_wr(1'b1);
    cyc(2);
    check("rerun pen", pb_pen, 1);
    rd(212);
    cyc(1);
    check("pre-rst level", fifo_level, 300);
    check("masked hef", status, 4'b0011);
    check("masked irq", irq, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async pen", pb_pen, 0);
    check("async level", fifo_level, 0);
    check("async empty", pb_empty, 1);
    check("async status", status, 0);
    check("async irq", irq, 0);
    check("async sm", pb_sm, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    check("post-rst status", status, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
